// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - VGA raster timing: pixel strobe, coordinates, video_on, active-low syncs
module vga_timing_controller #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS       = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS       = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [9:0]       h_next;
    logic [9:0]       v_next;

    assign p_tick = (div_cnt == DIV_LAST);
    assign x      = h_count;
    assign y      = v_count;

    // Sync/blank registers are fed from the next-state counts so they line up with x/y.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (p_tick) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            h_count  <= '0;
            v_count  <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            h_count  <= h_next;
            v_count  <= v_next;
            hsync    <= !((h_next >= H_SYNC_BEG) && (h_next <= H_SYNC_END));
            vsync    <= !((v_next >= V_SYNC_BEG) && (v_next <= V_SYNC_END));
            video_on <= (h_next < H_VIS) && (v_next < V_VIS);
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - bench for vga_timing_controller, default and small geometries
module tb_vga_timing_controller;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       a_tick, a_von, a_hs, a_vs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_von, b_hs, b_vs;
    logic [9:0] b_x, b_y;

    int total = 0;
    int bad = 0;
    int k = 0;

    always #5 clk = ~clk;

    vga_timing_controller dut_a (
        .clk_100MHz(clk), .reset(reset), .p_tick(a_tick), .x(a_x), .y(a_y),
        .video_on(a_von), .hsync(a_hs), .vsync(a_vs)
    );

    vga_timing_controller #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (
        .clk_100MHz(clk), .reset(reset), .p_tick(b_tick), .x(b_x), .y(b_y),
        .video_on(b_von), .hsync(b_hs), .vsync(b_vs)
    );

    // Expected outputs after the k-th clock edge following reset release (k=0: still in reset).
    function automatic exp_t ref_model(input int kk, input int d,
                                       input int hd, input int hf, input int hsw, input int hb,
                                       input int vd, input int vf, input int vsw, input int vb);
        exp_t e;
        int ht, vt, t, xx, yy;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        if (kk == 0) begin
            e.pt = 1'b0; e.x = '0; e.y = '0; e.von = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
        end else begin
            t  = kk / d;
            xx = t % ht;
            yy = (t / ht) % vt;
            e.pt  = ((kk % d) == d - 1);
            e.x   = 10'(xx);
            e.y   = 10'(yy);
            e.von = (xx < hd) && (yy < vd);
            e.hs  = !((xx >= hd + hf) && (xx < hd + hf + hsw));
            e.vs  = !((yy >= vd + vf) && (yy < vd + vf + vsw));
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got=%0d exp=%0d", tag, k, act, exp);
        end
    endtask

    task automatic check_both();
        exp_t ea, eb;
        ea = ref_model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        eb = ref_model(k, 2, 8, 2, 2, 2, 4, 1, 1, 1);
        chk("a_tick", 32'(a_tick), 32'(ea.pt));
        chk("a_x",    32'(a_x),    32'(ea.x));
        chk("a_y",    32'(a_y),    32'(ea.y));
        chk("a_von",  32'(a_von),  32'(ea.von));
        chk("a_hs",   32'(a_hs),   32'(ea.hs));
        chk("a_vs",   32'(a_vs),   32'(ea.vs));
        chk("b_tick", 32'(b_tick), 32'(eb.pt));
        chk("b_x",    32'(b_x),    32'(eb.x));
        chk("b_y",    32'(b_y),    32'(eb.y));
        chk("b_von",  32'(b_von),  32'(eb.von));
        chk("b_hs",   32'(b_hs),   32'(eb.hs));
        chk("b_vs",   32'(b_vs),   32'(eb.vs));
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        #1 check_both();
    endtask

    task automatic run_checked(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
            check_both();
        end
    endtask

    initial begin
        int a_hs_low, a_ticks, b_vs_low, run_len, hold;

        // Reset held across several edges
        k = 0;
        repeat (3) begin
            @(posedge clk);
            #1 check_both();
        end

        release_reset();

        // First line of the default geometry plus the small geometry's first frame
        a_hs_low = 0;
        a_ticks  = 0;
        b_vs_low = 0;
        repeat (3300) begin
            @(posedge clk);
            #1;
            k++;
            check_both();
            if (k <= 3200) begin
                if (a_hs === 1'b0) a_hs_low++;
                if (a_tick === 1'b1) a_ticks++;
            end
            if (k <= 196 && b_vs === 1'b0) b_vs_low++;
            if (k == 3200) begin
                chk("line_wrap_x", 32'(a_x), 32'd0);
                chk("line_wrap_y", 32'(a_y), 32'd1);
            end
            if (k == 196) begin
                chk("frame_wrap_bx", 32'(b_x), 32'd0);
                chk("frame_wrap_by", 32'(b_y), 32'd0);
            end
        end
        chk("a_hsync_low_clocks", 32'(a_hs_low), 32'd384);
        chk("a_ticks_per_line",   32'(a_ticks),  32'd800);
        chk("b_vsync_low_clocks", 32'(b_vs_low), 32'd28);

        // Random run lengths, then reset asserted between clock edges
        for (int r = 0; r < 5; r++) begin
            run_len = int'($urandom_range(100, 3000));
            hold    = int'($urandom_range(1, 3));
            run_checked(run_len);
            #(int'($urandom_range(1, 3)));
            reset = 1'b1;
            k = 0;
            #1 check_both();
            repeat (hold) begin
                @(posedge clk);
                #1 check_both();
            end
            release_reset();
            run_checked(int'($urandom_range(10, 400)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
